// File: rtl/clic_ip_gateway_if.sv
// Claim handshake between the CLIC arbiter/core side and the ip gateway.
//   claim_valid_i  master->gateway  claim request
//   claim_id_i     master->gateway  claimed source index
//   claim_ready_o  gateway->master  claim can be accepted this cycle
//   claim_err_o    gateway->master  1-cycle pulse: accepted claim had an out-of-range id
interface clic_ip_gateway_if #(
  parameter int N_SOURCE = 32
);
  localparam int SrcIdWidth = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;

  logic                  claim_valid_i;
  logic [SrcIdWidth-1:0] claim_id_i;
  logic                  claim_ready_o;
  logic                  claim_err_o;

  modport master (output claim_valid_i, claim_id_i, input claim_ready_o, claim_err_o);
  modport slave  (input claim_valid_i, claim_id_i, output claim_ready_o, claim_err_o);
endinterface

// File: rtl/clic_ip_gateway.sv
// Per-source interrupt-pending generator for the CLIC register adapter.
// Samples raw lines with level/edge and polarity attributes, applies software ip
// writes and core claim clears, and flags edges that hit an already-pending ip.
//   clk_i, rst_i   clock, synchronous active-high reset
//   intr_src_i     raw interrupt lines (already synchronous)
//   le_i, pol_i    trigger mode (1=edge) and polarity (1=active-low/falling)
//   sw_we_i/wd_i   software ip write strobe/data
//   claim_if       claim handshake (valid/id in, ready/err out)
//   ip_o, ovr_o    pending vector and sticky overrun flags
module clic_ip_gateway #(
  parameter int N_SOURCE = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] intr_src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] pol_i,
  input  logic [N_SOURCE-1:0] sw_we_i,
  input  logic [N_SOURCE-1:0] sw_wd_i,
  clic_ip_gateway_if.slave    claim_if,
  output logic [N_SOURCE-1:0] ip_o,
  output logic [N_SOURCE-1:0] ovr_o
);
  localparam int SrcIdWidth = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [N_SOURCE-1:0] act, rise;
  logic [N_SOURCE-1:0] act_q;
  logic [N_SOURCE-1:0] ip_q, ip_d;
  logic [N_SOURCE-1:0] ovr_q, ovr_d;
  logic                claim_acc, id_ok;
  logic                err_q, err_d;

  assign act  = intr_src_i ^ pol_i;
  assign rise = act & ~act_q;

  // The id port can encode values beyond N_SOURCE when N_SOURCE is not a power of 2.
  assign id_ok = 32'(claim_if.claim_id_i) < N_SOURCE;

  // Claim FSM: one accept, then one dead cycle.
  always_comb begin
    state_d   = state_q;
    claim_acc = 1'b0;
    case (state_q)
      IDLE: if (claim_if.claim_valid_i) begin
        claim_acc = 1'b1;
        state_d   = BUSY;
      end
      BUSY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign err_d = claim_acc & ~id_ok;

  // Per-source next state. In edge mode a new edge outranks a same-cycle claim so
  // the edge is never lost.
  always_comb begin
    ip_d  = ip_q;
    ovr_d = ovr_q;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (!le_i[i]) begin
        ip_d[i] = act[i];
      end else if (rise[i]) begin
        ip_d[i] = 1'b1;
        if (ip_q[i]) ovr_d[i] = 1'b1;
      end else if (sw_we_i[i]) begin
        ip_d[i] = sw_wd_i[i];
      end else if (claim_acc && id_ok && claim_if.claim_id_i == SrcIdWidth'(i)) begin
        ip_d[i]  = 1'b0;
        ovr_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      act_q   <= '0;
      ip_q    <= '0;
      ovr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act;
      ip_q    <= ip_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  assign ip_o                   = ip_q;
  assign ovr_o                  = ovr_q;
  assign claim_if.claim_ready_o = (state_q == IDLE);
  assign claim_if.claim_err_o   = err_q;
endmodule

// File: tb/tb_clic_ip_gateway.sv
module tb_clic_ip_gateway;
  localparam int N = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src, le, pol, we, wd;
  logic [N-1:0] ip, ovr;

  clic_ip_gateway_if #(.N_SOURCE(N)) cif ();

  clic_ip_gateway #(.N_SOURCE(N)) dut (
    .clk_i(clk), .rst_i(rst), .intr_src_i(src), .le_i(le), .pol_i(pol),
    .sw_we_i(we), .sw_wd_i(wd), .claim_if(cif), .ip_o(ip), .ovr_o(ovr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: what each source should hold after the coming clock edge.
  bit m_prev [N];
  bit m_ip   [N];
  bit m_ovr  [N];
  bit m_ready = 1'b1;
  bit m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit accepted;
    int cid;
    bit a;
    cid = int'(cif.claim_id_i);
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_prev[i] = 0; m_ip[i] = 0; m_ovr[i] = 0; end
      m_ready = 1; m_err = 0;
      return;
    end
    accepted = m_ready && cif.claim_valid_i;
    for (int i = 0; i < N; i++) begin
      a = src[i] ^ pol[i];
      if (!le[i]) m_ip[i] = a;
      else if (a && !m_prev[i]) begin
        if (m_ip[i]) m_ovr[i] = 1;
        m_ip[i] = 1;
      end else if (we[i]) m_ip[i] = wd[i];
      else if (accepted && cid == i) begin m_ip[i] = 0; m_ovr[i] = 0; end
      m_prev[i] = a;
    end
    m_err   = accepted && (cid >= N);
    m_ready = !accepted;
  endtask

  // Advance one clock, then compare all outputs against the model.
  task automatic cycle();
    logic [N-1:0] e_ip, e_ovr;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin e_ip[i] = m_ip[i]; e_ovr[i] = m_ovr[i]; end
    chk("ip",    32'(ip),  32'(e_ip));
    chk("ovr",   32'(ovr), 32'(e_ovr));
    chk("ready", 32'(cif.claim_ready_o), 32'(m_ready));
    chk("err",   32'(cif.claim_err_o),   32'(m_err));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; src = '0; le = '0; pol = '0; we = '0; wd = '0;
    cif.claim_valid_i = 0; cif.claim_id_i = '0;
    pol[5] = 1; src[5] = 1;               // source 5 active-low, idle
    le[3] = 1; le[7] = 1; le[9] = 1;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_ip", 32'(ip), 32'd0);
    chk("rst_ready", 32'(cif.claim_ready_o), 32'd1);
    rst = 0;
    cycle();

    // 1: edge rise on 3, latched after source falls
    src[3] = 1; cycle();
    chk("t1_ip3", 32'(ip[3]), 32'd1);
    src[3] = 0; cycle(); cycle();
    chk("t1_ip3_hold", 32'(ip[3]), 32'd1);
    chk("t1_ovr3", 32'(ovr[3]), 32'd0);

    // 2: second edge while pending -> overrun; claim clears both
    src[3] = 1; cycle();
    chk("t2_ovr3", 32'(ovr[3]), 32'd1);
    src[3] = 0; cif.claim_valid_i = 1; cif.claim_id_i = 5'd3; cycle();
    chk("t2_ip3_clr", 32'(ip[3]), 32'd0);
    chk("t2_ovr3_clr", 32'(ovr[3]), 32'd0);
    chk("t2_busy", 32'(cif.claim_ready_o), 32'd0);
    cif.claim_valid_i = 0; cycle();
    chk("t2_ready", 32'(cif.claim_ready_o), 32'd1);

    // 3: level, active-low source 5 held active 4 cycles; sw write ignored
    src[5] = 0; we[5] = 1; wd[5] = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_ip5_hi", 32'(ip[5]), 32'd1);
    end
    src[5] = 1; cycle();
    chk("t3_ip5_lo", 32'(ip[5]), 32'd0);
    we[5] = 0; cycle();

    // 4: claim of 7 coincides with a new edge on 7; sw set on 9
    src[7] = 1; cif.claim_valid_i = 1; cif.claim_id_i = 5'd7; cycle();
    chk("t4_ip7", 32'(ip[7]), 32'd1);
    cif.claim_valid_i = 0; we[9] = 1; wd[9] = 1; cycle();
    chk("t4_ip9", 32'(ip[9]), 32'd1);
    we[9] = 0; wd[9] = 0; cycle();

    // 5: out-of-range claim held through BUSY
    cif.claim_valid_i = 1; cif.claim_id_i = 5'd25;
    cycle(); chk("t5_err1", 32'(cif.claim_err_o), 32'd1);
    cycle(); chk("t5_err0", 32'(cif.claim_err_o), 32'd0);
    chk("t5_ready", 32'(cif.claim_ready_o), 32'd1);
    cycle(); chk("t5_err2", 32'(cif.claim_err_o), 32'd1);
    cif.claim_valid_i = 0; cycle();

    // 6: reset while BUSY with ip/ovr set
    src[3] = 1; cycle(); src[3] = 0; cycle(); src[3] = 1; cycle();
    cif.claim_valid_i = 1; cif.claim_id_i = 5'd0; cycle();
    cif.claim_valid_i = 0; rst = 1; cycle();
    chk("t6_ip", 32'(ip), 32'd0);
    chk("t6_ovr", 32'(ovr), 32'd0);
    chk("t6_ready", 32'(cif.claim_ready_o), 32'd1);
    rst = 0; cycle();

    // Random traffic including mode/polarity changes and rare resets
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) begin le = N'($urandom); pol = N'($urandom); end
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) src[i] = ~src[i];
      we = N'($urandom) & N'($urandom) & N'($urandom);
      wd = N'($urandom);
      cif.claim_valid_i = ($urandom_range(0, 2) == 0);
      cif.claim_id_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, N - 1));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
